// File: rtl/regfile_sb.sv
// -----------------------------------------------------------------------------
// regfile_sb
//
// Integer register file with an integrated issue scoreboard.
//
// Two combinational read ports, one synchronous writeback port, and a
// per-register pending bit that tracks instructions which have issued but not
// yet written back. An issuing instruction stalls while any of its sources
// (RAW) or its destination (WAW) is pending. Register 0 is hardwired to zero
// and is never pending.
//
// Optional feature macro: REGFILE_BYPASS_EN
//   defined   : write-through forwarding. A writeback in the current cycle is
//               forwarded to the read ports, and its pending bit is treated
//               as already clear for hazard checking, so a dependent
//               instruction issues in the same cycle as the writeback.
//   undefined : reads come from the array only and hazards use the registered
//               pending bits. A dependent instruction issues one cycle after
//               its producer writes back.
//
// Ports
//   clk       in   rising-edge clock
//   reset     in   asynchronous, active-high reset (clears regs, pend, count)
//   rr1, rr2  in   read addresses (issuing instruction's rs1 / rs2)
//   rd1, rd2  out  read data, combinational
//   we        in   writeback valid
//   wr        in   writeback address (0 is ignored)
//   wd        in   writeback data
//   iss_valid in   an instruction is presented for issue
//   iss_wr    in   destination of the issuing instruction (0 = none)
//   stall     out  issue blocked this cycle
//   flush     in   synchronous clear of all pending bits
//   pend_cnt  out  number of registers currently pending (registered)
//
// Issue handshake: iss_valid is the valid and !stall is the ready. An issue is
// accepted on a rising edge where iss_valid=1 and stall=0; a stalled
// instruction must be held by the issuer until it is accepted. stall is 0
// whenever iss_valid is 0, and it is derived only from registered pending
// state and current inputs, so there is no loop back into iss_valid.
// -----------------------------------------------------------------------------
module regfile_sb #(
    parameter int XLEN = 32,
    parameter int AW   = 5
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [AW-1:0]   rr1,
    input  logic [AW-1:0]   rr2,
    output logic [XLEN-1:0] rd1,
    output logic [XLEN-1:0] rd2,
    input  logic            we,
    input  logic [AW-1:0]   wr,
    input  logic [XLEN-1:0] wd,
    input  logic            iss_valid,
    input  logic [AW-1:0]   iss_wr,
    output logic            stall,
    input  logic            flush,
    output logic [AW:0]     pend_cnt
);

    localparam int NREG = 2 ** AW;

    // One-hot decode of a register address.
    function automatic logic [NREG-1:0] onehot(input logic [AW-1:0] a);
        logic [NREG-1:0] v;
        v    = '0;
        v[a] = 1'b1;
        return v;
    endfunction

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    // Entry 0 is reset to zero and never written; reads of address 0 are also
    // forced to zero explicitly so the intent does not depend on that entry.
    logic [XLEN-1:0] regs [NREG];
    logic [NREG-1:0] pend;
    logic [AW:0]     cnt_q;

    // -------------------------------------------------------------------------
    // Writeback decode
    // -------------------------------------------------------------------------
    logic            wb_hit;
    logic [NREG-1:0] wb_vec;

    assign wb_hit = we && (wr != '0);
    assign wb_vec = wb_hit ? onehot(wr) : '0;

    // -------------------------------------------------------------------------
    // Read ports
    // -------------------------------------------------------------------------
    logic [XLEN-1:0] arr_rd1;
    logic [XLEN-1:0] arr_rd2;

    assign arr_rd1 = (rr1 == '0) ? '0 : regs[rr1];
    assign arr_rd2 = (rr2 == '0) ? '0 : regs[rr2];

    // Registers whose pending bit is hidden from the hazard check this cycle.
    logic [NREG-1:0] haz_mask;

`ifdef REGFILE_BYPASS_EN
    // Forward the in-flight writeback to any port reading the same register,
    // and treat that register as no longer pending for this cycle's issue.
    assign rd1      = (wb_hit && (rr1 == wr)) ? wd : arr_rd1;
    assign rd2      = (wb_hit && (rr2 == wr)) ? wd : arr_rd2;
    assign haz_mask = wb_vec;
`else
    assign rd1      = arr_rd1;
    assign rd2      = arr_rd2;
    assign haz_mask = '0;
`endif

    // -------------------------------------------------------------------------
    // Hazard detection and issue accept
    // -------------------------------------------------------------------------
    logic [NREG-1:0] pend_vis;
    logic            hazard;
    logic            accept;
    logic            set_hit;
    logic [NREG-1:0] set_vec;

    assign pend_vis = pend & ~haz_mask;
    assign hazard   = pend_vis[rr1] | pend_vis[rr2] | pend_vis[iss_wr];
    assign stall    = iss_valid && hazard;
    assign accept   = iss_valid && !hazard;

    // An accepted issue with a real destination marks it pending. flush on the
    // same edge overrides the set.
    assign set_hit  = accept && (iss_wr != '0) && !flush;
    assign set_vec  = set_hit ? onehot(iss_wr) : '0;

    // -------------------------------------------------------------------------
    // Next pending state and count
    // -------------------------------------------------------------------------
    logic [NREG-1:0] pend_nxt;
    logic            cnt_inc;
    logic            cnt_dec;
    logic [AW:0]     cnt_nxt;

    // Clear from writeback is applied first so that a same-edge set of the
    // same register wins and leaves the bit at 1.
    always_comb begin
        pend_nxt = (pend & ~wb_vec) | set_vec;
        if (flush) begin
            pend_nxt = '0;
        end
    end

    // Count tracks bit transitions rather than recounting the vector:
    //   inc : a set lands on a bit that was clear
    //   dec : a clear lands on a bit that was set, and is not overridden by a
    //         same-edge set of that register
    assign cnt_inc = set_hit && !pend[iss_wr];
    assign cnt_dec = wb_hit && pend[wr] && !(set_hit && (iss_wr == wr));

    always_comb begin
        cnt_nxt = cnt_q;
        if (flush) begin
            cnt_nxt = '0;
        end else if (cnt_inc && !cnt_dec) begin
            cnt_nxt = cnt_q + 1'b1;
        end else if (cnt_dec && !cnt_inc) begin
            cnt_nxt = cnt_q - 1'b1;
        end
    end

    assign pend_cnt = cnt_q;

    // -------------------------------------------------------------------------
    // Sequential state
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (wb_hit) begin
            regs[wr] <= wd;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend  <= '0;
            cnt_q <= '0;
        end else begin
            pend  <= pend_nxt;
            cnt_q <= cnt_nxt;
        end
    end

endmodule

// File: doc/regfile_sb.md
# regfile_sb

Clocked, parametrised integer register file with an integrated scoreboard, replacing the edge-on-write-enable register file in the CPU datapath. It provides two combinational read ports and one synchronous writeback port. It tracks a per-register pending bit for instructions issued but not yet written back, and raises a stall for RAW/WAW hazards at issue. Register 0 is hardwired to zero.

## Interface
- XLEN, 32, data width of each register
- AW, 5, register address width; NREG = 2**AW registers
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- rr1  in  AW  read address, port 1 (issuing instruction's rs1)
- rr2  in  AW  read address, port 2 (issuing instruction's rs2)
- rd1  out  XLEN  read data, port 1
- rd2  out  XLEN  read data, port 2
- we  in  1  writeback valid
- wr  in  AW  writeback address
- wd  in  XLEN  writeback data
- iss_valid  in  1  instruction presented for issue
- iss_wr  in  AW  destination of issuing instruction; 0 = no destination
- stall  out  1  issue blocked this cycle
- flush  in  1  synchronous clear of all pending bits
- pend_cnt  out  AW+1  number of pending registers

## Operation
- Storage: regs[1..NREG-1] of XLEN bits; regs[0] does not exist and reads 0. pend[NREG-1:0] has pend[0] tied to 0.
- Reads are combinational: rd1 = (rr1==0) ? 0 : regs[rr1]; likewise rd2.
- Writeback: on posedge clk, if we && wr!=0, regs[wr] <= wd and pend[wr] <= 0. Writeback to a non-pending register is a plain write. we with wr==0 is ignored.
- hazard = pend[rr1] | pend[rr2] | pend[iss_wr] (RAW on either source, WAW on the destination).
- stall = iss_valid && hazard. Combinational; 0 whenever iss_valid=0.
- Issue accept = iss_valid && !stall. On posedge, if accepted and iss_wr!=0, pend[iss_wr] <= 1.
- Same-edge accept and writeback to the same nonzero register: the set wins, and pend stays 1. regs is still updated with wd.
- flush: on posedge, all pend bits are cleared. flush has priority over an issue set on the same edge. regs writeback still occurs.
- pend_cnt is a registered counter maintained incrementally: +1 on an effective set of a clear bit, −1 on an effective clear of a set bit, net 0 for both on the same edge. flush loads 0. It never exceeds NREG-1.

## Timing
- reset (async): all regs = 0, pend = 0, pend_cnt = 0. Hence rd1 = rd2 = 0 and stall = 0.
- Reset asserted mid-operation clears everything immediately, without waiting for a clock edge. The first edge after deassertion behaves as a normal cycle.
- Read latency is 0 cycles. Write latency is 1 edge: data written at edge N is visible on rd from after edge N.
- Scoreboard latency: a register issued at edge N stalls dependents from after N. Writeback at edge M releases dependents after M, unless bypass is compiled in (see Configuration).
- The stall path depends only on the registered pend and current inputs. There is no combinational loop with iss_valid.

## Configuration
- REGFILE_BYPASS_EN defined: write-through forwarding is enabled.
  - If we && wr!=0 && rr1==wr, then rd1 = wd in the same cycle; likewise rd2.
  - hazard terms for the register being written back this cycle are masked, so a dependent instruction issues in the same cycle as the writeback.
  - A masked WAW issue to wr sets pend[wr] (set wins).
- Not defined: rd always comes from the array and hazard uses the raw pend. A dependent instruction issues one cycle after writeback.

## Test plan
- Reset with regs preloaded by writes, assert reset between edges -> rd1=rd2=0, pend_cnt=0, stall=0 immediately. Write x0 with 0xDEADBEEF -> rd1(rr1=0)=0.
- Write x5=0x12345678, x6=0xCAFEF00D -> next cycle rr1=5, rr2=6 read exactly those values. rr1=rr2=5 gives both ports 0x12345678.
- Issue iss_wr=7; next cycle iss_valid with rr1=7 -> stall=1 and pend_cnt=1. Writeback x7=0x55 -> pend_cnt=0.
  - Without bypass: stall=1 on the writeback cycle and 0 the cycle after.
  - With REGFILE_BYPASS_EN: stall=0 and rd1=0x55 on the writeback cycle.
- WAW: x9 pending, issue iss_wr=9 with rr1=rr2=0 -> stall=1. Without bypass, after writeback of x9 the issue accepts and pend_cnt returns to 1.
- Same-edge issue x3 (accepted) and writeback x4 -> pend_cnt unchanged (+1 −1), pend[3]=1, pend[4]=0.
- Issue x1, x2, x3 on consecutive cycles (pend_cnt=3), then flush together with iss_valid, iss_wr=4 -> pend_cnt=0, no register pending, rr1=4 does not stall the following cycle.
